scratch_pad_stream_master: RTL

- Requester that drives one port of the multi-port scratch pad.
- Accepts a block command (base address, word count, read or write) and issues one request per cycle on the port's rd_en/wr_en/addr/d lines, honouring the port's full signal.
- Tracks outstanding reads against the reorder-queue depth.
- Streams write data in from an upstream source and passes in-order read returns to a downstream consumer with stall back-pressure.
- One instance sits on each scratch pad port used by a compute engine.

---
 rtl/scratch_pad_stream_master.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scratch_pad_stream_master.sv
// Purpose : block-command requester for one scratch pad port; issues one read/write per cycle.
// Latency : first request the cycle after command accept; done pulses one cycle after the last
//           write, or one cycle after the last read return has been counted.
// Backpressure: requests held while sp_full is high, while write data is absent, or while
//           MAX_OUTSTANDING reads are in flight; read returns pass straight through with stall.
// Ports   : clk/rst (sync, active-low) | cmd_* block command | wr_data* upstream write stream |
//           rd_data* downstream read stream | sp_* scratch pad port | busy/done status.
module scratch_pad_stream_master #(
   parameter int WIDTH           = 64,
   parameter int ADDR_WIDTH      = 12,
   parameter int LEN_WIDTH       = 13,
   parameter int MAX_OUTSTANDING = 32,
   parameter int OUT_BITS        = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  wr_data_valid,
   output logic                  wr_data_ready,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_data_valid,
   input  logic                  rd_data_stall,
   output logic                  sp_rd_en,
   output logic                  sp_wr_en,
   output logic [ADDR_WIDTH-1:0] sp_addr,
   output logic [WIDTH-1:0]      sp_d,
   input  logic                  sp_full,
   input  logic [WIDTH-1:0]      sp_q,
   input  logic                  sp_valid,
   output logic                  sp_stall,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [OUT_BITS-1:0] MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);

   state_t                state, state_nxt;
   logic                  is_write;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [OUT_BITS-1:0]   outstanding;
   logic                  issue;
   logic                  w_go;
   logic                  r_go;
   logic                  out_dec;

   assign w_go = wr_data_valid && !sp_full;
   assign r_go = !sp_full && (outstanding < MAX_OUT);

   // A return with nothing counted in flight is a stray: forwarded, never counted.
   assign out_dec = sp_valid && (outstanding != '0);

   // Read return path is a pure pass-through; the scratch pad holds data under stall.
   assign rd_data       = sp_q;
   assign rd_data_valid = sp_valid;
   assign sp_stall      = rd_data_stall;
   assign sp_d          = wr_data;
   assign sp_addr       = cur_addr;
   assign busy          = (state != IDLE);
   assign done          = (state == FINISH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         is_write    <= 1'b0;
         cur_addr    <= '0;
         remaining   <= '0;
         outstanding <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cmd_valid) begin
            is_write  <= cmd_write;
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
         end else if (issue) begin
            // Address wraps modulo 2^ADDR_WIDTH by construction.
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
         end
         if (sp_rd_en && !out_dec) begin
            outstanding <= outstanding + OUT_BITS'(1);
         end else if (out_dec && !sp_rd_en) begin
            outstanding <= outstanding - OUT_BITS'(1);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cmd_ready     = 1'b0;
      sp_rd_en      = 1'b0;
      sp_wr_en      = 1'b0;
      wr_data_ready = 1'b0;
      issue         = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nxt = (cmd_len == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            if (is_write) begin
               if (w_go) begin
                  sp_wr_en      = 1'b1;
                  wr_data_ready = 1'b1;
                  issue         = 1'b1;
                  if (remaining == LEN_WIDTH'(1)) state_nxt = FINISH;
               end
            end else begin
               if (r_go) begin
                  sp_rd_en = 1'b1;
                  issue    = 1'b1;
                  if (remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (outstanding == '0) state_nxt = FINISH;
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
